// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single fixed-latency memory.
// Define LS_PRIORITY_EN to make ls win every tie instead of round-robin.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [15:0] ls_addr,
    input  logic [15:0] ls_wdata,
    output logic [15:0] ls_rdata,
    output logic        ls_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        selLs_q, selLs_d;
    logic        lastLs_q, lastLs_d;
    logic        weLat_q, weLat_d;
    logic        memEn_q, memEn_d;
    logic        memWe_q, memWe_d;
    logic [15:0] memAddr_q, memAddr_d;
    logic [15:0] memWdata_q, memWdata_d;
    logic [15:0] ifRdata_q, ifRdata_d;
    logic [15:0] lsRdata_q, lsRdata_d;
    logic        ifReady_q, ifReady_d;
    logic        lsReady_q, lsReady_d;

    logic        tieLs;
    logic        grantLs;

`ifdef LS_PRIORITY_EN
    assign tieLs = 1'b1;
`else
    // Round-robin: on a tie the port that was not granted last time wins.
    assign tieLs = ~lastLs_q;
`endif

    assign grantLs = ls_req & (~if_req | tieLs);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        selLs_d    = selLs_q;
        lastLs_d   = lastLs_q;
        weLat_d    = weLat_q;
        memEn_d    = 1'b0;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        ifRdata_d  = ifRdata_q;
        lsRdata_d  = lsRdata_q;
        ifReady_d  = 1'b0;
        lsReady_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    selLs_d    = grantLs;
                    lastLs_d   = grantLs;
                    weLat_d    = grantLs & ls_we;
                    memEn_d    = 1'b1;
                    memWe_d    = grantLs & ls_we;
                    memAddr_d  = grantLs ? ls_addr : if_addr;
                    memWdata_d = grantLs ? ls_wdata : memWdata_q;
                    cnt_d      = CNT_LOAD;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // The cycle the counter reaches zero is the one whose closing edge samples read data.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!weLat_q) begin
                        if (selLs_q) begin
                            lsRdata_d = mem_rdata;
                        end else begin
                            ifRdata_d = mem_rdata;
                        end
                    end
                    ifReady_d = ~selLs_q;
                    lsReady_d = selLs_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            selLs_q    <= 1'b0;
            lastLs_q   <= 1'b1;
            weLat_q    <= 1'b0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= 16'h0000;
            memWdata_q <= 16'h0000;
            ifRdata_q  <= 16'h0000;
            lsRdata_q  <= 16'h0000;
            ifReady_q  <= 1'b0;
            lsReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            selLs_q    <= selLs_d;
            lastLs_q   <= lastLs_d;
            weLat_q    <= weLat_d;
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ifRdata_q  <= ifRdata_d;
            lsRdata_q  <= lsRdata_d;
            ifReady_q  <= ifReady_d;
            lsReady_q  <= lsReady_d;
        end
    end

    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign if_rdata  = ifRdata_q;
    assign ls_rdata  = lsRdata_q;
    assign if_ready  = ifReady_q;
    assign ls_ready  = lsReady_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline reference model with random two-port traffic, plus
// directed fetch/store/tie/reset cases and latency-1 / latency-15 side instances.
module tb_mem_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    logic ifReq, lsReq, lsWe;
    logic [15:0] ifAddr, lsAddr, lsWdata, memRdata;
    logic [15:0] ifRdata, lsRdata, memAddr, memWdata;
    logic ifReady, lsReady, memEn, memWe, busy;

    logic [1:0] sIfReq, sLsReq, sIfReady, sLsReady, sMemEn, sMemWe, sBusy;
    logic [1:0][15:0] sIfAddr, sLsAddr, sIfRdata, sLsRdata, sMemAddr, sMemWdata, sMemRdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] refMem [int];
    logic [15:0] envMem [int];
    bit accValid;
    int accStart;
    int gPort;
    logic [15:0] gAddr, gWdata;
    bit gWe;
    bit lastLs;
    logic [15:0] expRd [2];
    logic [15:0] expMemAddr;
    bit envPend;
    int envLeft;
    logic [15:0] envAddr;
    bit pending [2];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
        .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wdata(lsWdata),
        .ls_rdata(lsRdata), .ls_ready(lsReady),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LATENCY(1)) dutL1 (
        .clk(clk), .rst(rst),
        .if_req(sIfReq[0]), .if_addr(sIfAddr[0]), .if_rdata(sIfRdata[0]), .if_ready(sIfReady[0]),
        .ls_req(sLsReq[0]), .ls_we(1'b0), .ls_addr(sLsAddr[0]), .ls_wdata(16'h0000),
        .ls_rdata(sLsRdata[0]), .ls_ready(sLsReady[0]),
        .mem_en(sMemEn[0]), .mem_we(sMemWe[0]), .mem_addr(sMemAddr[0]), .mem_wdata(sMemWdata[0]),
        .mem_rdata(sMemRdata[0]), .busy(sBusy[0])
    );

    mem_arbiter #(.MEM_LATENCY(15)) dutL15 (
        .clk(clk), .rst(rst),
        .if_req(sIfReq[1]), .if_addr(sIfAddr[1]), .if_rdata(sIfRdata[1]), .if_ready(sIfReady[1]),
        .ls_req(sLsReq[1]), .ls_we(1'b0), .ls_addr(sLsAddr[1]), .ls_wdata(16'h0000),
        .ls_rdata(sLsRdata[1]), .ls_ready(sLsReady[1]),
        .mem_en(sMemEn[1]), .mem_we(sMemWe[1]), .mem_addr(sMemAddr[1]), .mem_wdata(sMemWdata[1]),
        .mem_rdata(sMemRdata[1]), .busy(sBusy[1])
    );

    // Side memories simply return the inverted address.
    assign sMemRdata[0] = ~sMemAddr[0];
    assign sMemRdata[1] = ~sMemAddr[1];

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        return refMem.exists(int'(a)) ? refMem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [15:0] rndAddr();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return {12'h000, 4'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        accValid   = 1'b0;
        lastLs     = 1'b1;
        gWe        = 1'b0;
        expRd[0]   = 16'h0000;
        expRd[1]   = 16'h0000;
        expMemAddr = 16'h0000;
        envPend    = 1'b0;
        pending[0] = 1'b0;
        pending[1] = 1'b0;
    endtask

    // Timeline model: an access granted at the end of cycle n owns cycles n+1 .. n+1+L.
    task automatic modelUpdate();
        bit idle;
        bit pickLs;
        idle = !(accValid && cyc <= accStart + L);
        if (!rst && idle && (ifReq || lsReq)) begin
            if (ifReq && lsReq) begin
`ifdef LS_PRIORITY_EN
                pickLs = 1'b1;
`else
                pickLs = !lastLs;
`endif
            end else begin
                pickLs = lsReq;
            end
            gPort      = pickLs ? 1 : 0;
            accValid   = 1'b1;
            accStart   = cyc + 1;
            gAddr      = pickLs ? lsAddr : ifAddr;
            gWe        = pickLs && lsWe;
            gWdata     = lsWdata;
            lastLs     = pickLs;
            expMemAddr = gAddr;
            if (gWe) refMem[int'(gAddr)] = gWdata;
        end
    endtask

    task automatic checkOutput();
        bit busyE, doneE;
        busyE = accValid && cyc >= accStart && cyc <= accStart + L;
        doneE = accValid && cyc == accStart + L;
        if (doneE && !gWe) expRd[gPort] = refRead(gAddr);
        chkBit("busy", busy, busyE);
        chkBit("mem_en", memEn, accValid && cyc == accStart);
        chkBit("mem_we", memWe, accValid && cyc == accStart && gWe);
        chkBit("if_ready", ifReady, doneE && gPort == 0);
        chkBit("ls_ready", lsReady, doneE && gPort == 1);
        chk("if_rdata", ifRdata, expRd[0]);
        chk("ls_rdata", lsRdata, expRd[1]);
        chk("mem_addr", memAddr, expMemAddr);
        if (busyE && gWe) chk("mem_wdata", memWdata, gWdata);
    endtask

    // Memory environment: read data is valid only in the cycle the DUT must sample it.
    task automatic memEnv();
        if (memEn && memWe) begin
            envMem[int'(memAddr)] = memWdata;
        end else if (memEn) begin
            envPend = 1'b1;
            envLeft = L - 1;
            envAddr = memAddr;
        end else if (envPend) begin
            envLeft--;
        end
        if (envPend && envLeft == 0) begin
            memRdata = envMem.exists(int'(envAddr)) ? envMem[int'(envAddr)] : dflt(envAddr);
            envPend  = 1'b0;
        end else begin
            memRdata = 16'($urandom);
        end
    endtask

    task automatic advance();
        modelUpdate();
        @(negedge clk);
        cyc++;
        checkOutput();
        memEnv();
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        refMem[int'(a)] = d;
        envMem[int'(a)] = d;
    endtask

    task automatic resetDut();
        rst   = 1'b1;
        ifReq = 1'b0;
        lsReq = 1'b0;
        modelReset();
        advance();
        advance();
        rst = 1'b0;
        advance();
    endtask

    task automatic scramble(input int p, input bit req);
        if (p == 0) begin
            ifReq  = req;
            ifAddr = rndAddr();
        end else begin
            lsReq   = req;
            lsAddr  = rndAddr();
            lsWdata = 16'($urandom);
            lsWe    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < 2; p++) begin
            bit active, doneNow;
            active  = accValid && gPort == p && cyc >= accStart && cyc < accStart + L;
            doneNow = accValid && gPort == p && cyc == accStart + L;
            if (doneNow) pending[p] = 1'b0;
            if (active) begin
                scramble(p, 1'b1);
            end else if (!pending[p]) begin
                if ($urandom_range(0, 2) == 0) begin
                    pending[p] = 1'b1;
                    scramble(p, 1'b1);
                end else begin
                    scramble(p, 1'b0);
                end
            end
        end
    endtask

    task automatic sideTest(input int k, input int lat, input bit useLs, input logic [15:0] a);
        int d;
        bit got;
        d = 0;
        got = 1'b0;
        if (useLs) begin
            sLsReq[k] = 1'b1;
            sLsAddr[k] = a;
        end else begin
            sIfReq[k] = 1'b1;
            sIfAddr[k] = a;
        end
        while (!got && d < 40) begin
            advance();
            d++;
            if (d == 1) begin
                chkBit("side mem_en", sMemEn[k], 1'b1);
                chkBit("side mem_we", sMemWe[k], 1'b0);
                chk("side mem_addr", sMemAddr[k], a);
            end
            got = useLs ? sLsReady[k] : sIfReady[k];
        end
        chk("side latency", 16'(d), 16'(lat + 1));
        chk("side rdata", useLs ? sLsRdata[k] : sIfRdata[k], ~a);
        sIfReq[k] = 1'b0;
        sLsReq[k] = 1'b0;
        advance();
        chkBit("side busy idle", sBusy[k], 1'b0);
    endtask

    initial begin
        int got[$];
        int tieExp[3];
        int d;
        bit seen;
`ifdef LS_PRIORITY_EN
        tieExp = '{1, 1, 1};
`else
        tieExp = '{0, 1, 0};
`endif
        ifReq = 1'b0; lsReq = 1'b0; lsWe = 1'b0;
        ifAddr = 16'h0; lsAddr = 16'h0; lsWdata = 16'h0; memRdata = 16'h0;
        sIfReq = '0; sLsReq = '0; sIfAddr = '0; sLsAddr = '0;
        rst = 1'b1;
        modelReset();
        advance();
        advance();
        chkBit("reset busy", busy, 1'b0);
        chkBit("reset mem_en", memEn, 1'b0);
        chk("reset mem_addr", memAddr, 16'h0000);
        chk("reset mem_wdata", memWdata, 16'h0000);
        chk("reset if_rdata", ifRdata, 16'h0000);
        rst = 1'b0;
        advance();

        // Single fetch at latency 2.
        preload(16'h3000, 16'h1F44);
        ifReq = 1'b1; ifAddr = 16'h3000;
        advance();
        chkBit("fetch mem_en T+1", memEn, 1'b1);
        chk("fetch mem_addr T+1", memAddr, 16'h3000);
        chkBit("fetch busy T+1", busy, 1'b1);
        advance();
        chkBit("fetch busy T+2", busy, 1'b1);
        chkBit("fetch if_ready T+2", ifReady, 1'b0);
        advance();
        chkBit("fetch if_ready T+3", ifReady, 1'b1);
        chk("fetch if_rdata T+3", ifRdata, 16'h1F44);
        chkBit("fetch busy T+3", busy, 1'b1);
        ifReq = 1'b0;
        advance();
        chkBit("fetch busy T+4", busy, 1'b0);

        // Single store.
        lsReq = 1'b1; lsWe = 1'b1; lsAddr = 16'h4000; lsWdata = 16'hABCD;
        advance();
        chkBit("store mem_en", memEn, 1'b1);
        chkBit("store mem_we", memWe, 1'b1);
        chk("store mem_wdata", memWdata, 16'hABCD);
        advance();
        chkBit("store mem_en off", memEn, 1'b0);
        advance();
        chkBit("store ls_ready", lsReady, 1'b1);
        chk("store ls_rdata kept", lsRdata, 16'h0000);
        lsReq = 1'b0; lsWe = 1'b0;
        advance();
        chkBit("store ls_ready once", lsReady, 1'b0);

        // Ties held across three accesses after reset.
        resetDut();
        ifReq = 1'b1; ifAddr = 16'h0100;
        lsReq = 1'b1; lsAddr = 16'h0200; lsWe = 1'b0;
        for (int i = 0; i < 40 && got.size() < 3; i++) begin
            advance();
            if (ifReady) got.push_back(0);
            if (lsReady) got.push_back(1);
        end
        ifReq = 1'b0; lsReq = 1'b0;
        chk("tie count", 16'(got.size()), 16'd3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("tie grant", 16'(got[i]), 16'(tieExp[i]));
        advance();
        advance();

        sideTest(0, 1, 1'b0, 16'hFFFF);
        sideTest(0, 1, 1'b1, 16'h0000);
        sideTest(1, 15, 1'b0, 16'hFFFF);
        sideTest(1, 15, 1'b1, 16'h0000);

        for (int i = 0; i < 800; i++) begin
            applyStimulus();
            advance();
        end
        ifReq = 1'b0; lsReq = 1'b0;
        pending[0] = 1'b0; pending[1] = 1'b0;
        for (int i = 0; i < 40 && accValid && cyc <= accStart + L; i++) advance();
        advance();

        // Reset during the second ACCESS cycle of a load.
        lsReq = 1'b1; lsWe = 1'b0; lsAddr = 16'h0005;
        advance();
        lsReq = 1'b0;
        advance();
        rst = 1'b1;
        #1;
        chkBit("abort busy", busy, 1'b0);
        chkBit("abort mem_en", memEn, 1'b0);
        chkBit("abort ls_ready", lsReady, 1'b0);
        chk("abort mem_addr", memAddr, 16'h0000);
        chk("abort ls_rdata", lsRdata, 16'h0000);
        chk("abort if_rdata", ifRdata, 16'h0000);
        modelReset();
        advance();
        advance();
        rst = 1'b0;
        advance();
        advance();

        preload(16'hBEEF, 16'h1234);
        lsReq = 1'b1; lsWe = 1'b0; lsAddr = 16'hBEEF;
        d = 0;
        seen = 1'b0;
        while (!seen && d < 40) begin
            advance();
            d++;
            seen = lsReady;
        end
        chk("restart latency", 16'(d), 16'(L + 1));
        chk("restart ls_rdata", lsRdata, 16'h1234);
        lsReq = 1'b0;
        advance();
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
